// File: rtl/nand_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nand_pkg
// Description : Shared op codes, bus-cycle types, NAND command bytes and the
//               sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package nand_pkg;

  typedef enum logic [1:0] {
    OP_RESET   = 2'd0,
    OP_READ    = 2'd1,
    OP_PROGRAM = 2'd2,
    OP_ERASE   = 2'd3
  } op_code_t;

  typedef enum logic [1:0] {
    CYC_CMD   = 2'd0,
    CYC_ADDR  = 2'd1,
    CYC_WDATA = 2'd2,
    CYC_RDATA = 2'd3
  } cyc_type_t;

  localparam logic [7:0] c_cmd_reset  = 8'hFF;
  localparam logic [7:0] c_cmd_read1  = 8'h00;
  localparam logic [7:0] c_cmd_read2  = 8'h30;
  localparam logic [7:0] c_cmd_prog1  = 8'h80;
  localparam logic [7:0] c_cmd_prog2  = 8'h10;
  localparam logic [7:0] c_cmd_erase1 = 8'h60;
  localparam logic [7:0] c_cmd_erase2 = 8'hD0;

  localparam int c_st_w = 4;
  typedef logic [c_st_w-1:0] seq_state_t;

  localparam seq_state_t c_st_idle    = 4'd0;
  localparam seq_state_t c_st_cmd1    = 4'd1;
  localparam seq_state_t c_st_addr    = 4'd2;
  localparam seq_state_t c_st_data    = 4'd3;
  localparam seq_state_t c_st_cmd2    = 4'd4;
  localparam seq_state_t c_st_twb     = 4'd5;
  localparam seq_state_t c_st_wait_rb = 4'd6;
  localparam seq_state_t c_st_trr     = 4'd7;
  localparam seq_state_t c_st_done    = 4'd8;

  function automatic logic [7:0] first_cmd(input op_code_t op);
    case (op)
      OP_RESET:   return c_cmd_reset;
      OP_READ:    return c_cmd_read1;
      OP_PROGRAM: return c_cmd_prog1;
      default:    return c_cmd_erase1;
    endcase
  endfunction

  // RESET has no confirm command; its value is never presented.
  function automatic logic [7:0] second_cmd(input op_code_t op);
    case (op)
      OP_READ:    return c_cmd_read2;
      OP_PROGRAM: return c_cmd_prog2;
      OP_ERASE:   return c_cmd_erase2;
      default:    return 8'h00;
    endcase
  endfunction

  // ERASE carries only the three row-address bytes.
  function automatic logic [2:0] addr_cycles(input op_code_t op);
    return (op == OP_ERASE) ? 3'd3 : 3'd5;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nand_rb_timer.sv
`default_nettype none
// ============================================================================
// Module      : nand_rb_timer
// Description : R/B# synchronizer plus tWB / tRR spacing and busy-timeout
//               counters for the NAND op sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module nand_rb_timer #(
  parameter int TWB_CYC  = 4,
  parameter int TRR_CYC  = 2,
  parameter int TOUT_W   = 16,
  parameter int TOUT_CYC = 16'hFFFF
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic F_nRB,
  input  logic start_twb,
  input  logic start_trr,
  input  logic rb_wait,
  output logic twb_done,
  output logic rb_ready,
  output logic trr_done,
  output logic timeout
);

  localparam int c_twb_w = $clog2(TWB_CYC + 1);
  localparam int c_trr_w = $clog2(TRR_CYC + 1);
  localparam logic [c_twb_w-1:0] c_twb_last = c_twb_w'(TWB_CYC - 1);
  localparam logic [c_trr_w-1:0] c_trr_last = c_trr_w'(TRR_CYC - 1);
  localparam logic [TOUT_W-1:0]  c_tout_last = TOUT_W'(TOUT_CYC - 1);

  logic               r_rb_meta;
  logic               r_rb_sync;
  logic               r_twb_act;
  logic [c_twb_w-1:0] r_twb_cnt;
  logic               r_trr_act;
  logic [c_trr_w-1:0] r_trr_cnt;
  logic [TOUT_W-1:0]  r_tout_cnt;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_rb_meta <= 1'b1;
      r_rb_sync <= 1'b1;
    end else begin
      r_rb_meta <= F_nRB;
      r_rb_sync <= r_rb_meta;
    end
  end

  assign rb_ready = r_rb_sync;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_twb_act <= 1'b0;
      r_twb_cnt <= '0;
    end else if (start_twb) begin
      r_twb_act <= 1'b1;
      r_twb_cnt <= '0;
    end else if (r_twb_act) begin
      if (twb_done) r_twb_act <= 1'b0;
      else          r_twb_cnt <= r_twb_cnt + c_twb_w'(1);
    end
  end

  assign twb_done = r_twb_act && (r_twb_cnt == c_twb_last);

  // The cycle in which ready is first seen already counts toward tRR.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_trr_act <= 1'b0;
      r_trr_cnt <= '0;
    end else if (start_trr) begin
      r_trr_act <= 1'b1;
      r_trr_cnt <= c_trr_w'(1);
    end else if (r_trr_act) begin
      if (trr_done) r_trr_act <= 1'b0;
      else          r_trr_cnt <= r_trr_cnt + c_trr_w'(1);
    end
  end

  assign trr_done = r_trr_act && (r_trr_cnt >= c_trr_last);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)        r_tout_cnt <= '0;
    else if (!rb_wait) r_tout_cnt <= '0;
    else if (!timeout) r_tout_cnt <= r_tout_cnt + TOUT_W'(1);
  end

  assign timeout = rb_wait && (r_tout_cnt == c_tout_last);

endmodule
`default_nettype wire

// File: rtl/nand_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : nand_op_sequencer
// Description : Turns one NAND operation descriptor into an ordered stream of
//               CMD/ADDR/DATA bus-cycle requests, including the R/B# wait.
// Revision    : 1.0 - initial release
// ============================================================================
module nand_op_sequencer #(
  parameter int LEN_W    = 12,
  parameter int TWB_CYC  = 4,
  parameter int TRR_CYC  = 2,
  parameter int TOUT_W   = 16,
  parameter int TOUT_CYC = 16'hFFFF
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_code,
  input  logic [39:0]      op_addr,
  input  logic [LEN_W-1:0] op_len,
  output logic             cyc_valid,
  input  logic             cyc_ready,
  output logic [1:0]       cyc_type,
  output logic [7:0]       cyc_data,
  input  logic             F_nRB,
  output logic             busy,
  output logic             done,
  output logic             err_timeout
);

  import nand_pkg::*;

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  op_code_t         r_op;
  logic [39:0]      r_addr;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_data_cnt;
  logic [2:0]       r_addr_cnt;
  logic             r_err_timeout;

  logic       w_accept;
  logic       w_xfer;
  logic       w_len_zero;
  logic       w_addr_last;
  logic       w_data_last;
  logic [2:0] w_addr_idx;
  logic [7:0] w_addr_byte;
  logic       w_start_twb;
  logic       w_start_trr;
  logic       w_rb_wait;
  logic       w_twb_done;
  logic       w_rb_ready;
  logic       w_trr_done;
  logic       w_timeout;

  assign w_accept    = op_valid && (r_state == c_st_idle);
  assign w_xfer      = cyc_valid && cyc_ready;
  assign w_len_zero  = (r_len == '0);
  assign w_addr_last = (r_addr_cnt == (addr_cycles(r_op) - 3'd1));
  assign w_data_last = (r_data_cnt == (r_len - LEN_W'(1)));
  // ERASE skips the two column bytes and starts at op_addr[23:16].
  assign w_addr_idx  = (r_op == OP_ERASE) ? (r_addr_cnt + 3'd2) : r_addr_cnt;

  always_comb begin
    case (w_addr_idx)
      3'd0:    w_addr_byte = r_addr[7:0];
      3'd1:    w_addr_byte = r_addr[15:8];
      3'd2:    w_addr_byte = r_addr[23:16];
      3'd3:    w_addr_byte = r_addr[31:24];
      default: w_addr_byte = r_addr[39:32];
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_state <= c_st_idle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:    if (op_valid) w_state_nxt = c_st_cmd1;
      c_st_cmd1:    if (w_xfer) w_state_nxt = (r_op == OP_RESET) ? c_st_twb : c_st_addr;
      c_st_addr: begin
        if (w_xfer && w_addr_last)
          w_state_nxt = (r_op == OP_PROGRAM && !w_len_zero) ? c_st_data : c_st_cmd2;
      end
      c_st_data: begin
        if (w_xfer && w_data_last)
          w_state_nxt = (r_op == OP_READ) ? c_st_done : c_st_cmd2;
      end
      c_st_cmd2:    if (w_xfer) w_state_nxt = c_st_twb;
      c_st_twb:     if (w_twb_done) w_state_nxt = c_st_wait_rb;
      c_st_wait_rb: begin
        // Ready takes priority over a timeout landing on the same cycle.
        if (w_rb_ready)     w_state_nxt = (r_op == OP_READ) ? c_st_trr : c_st_done;
        else if (w_timeout) w_state_nxt = c_st_done;
      end
      c_st_trr:     if (w_trr_done) w_state_nxt = w_len_zero ? c_st_done : c_st_data;
      c_st_done:    w_state_nxt = c_st_idle;
      default:      w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    op_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    cyc_valid = 1'b0;
    cyc_type  = CYC_CMD;
    cyc_data  = 8'h00;
    case (r_state)
      c_st_idle: begin
        op_ready = 1'b1;
        busy     = 1'b0;
      end
      c_st_cmd1: begin
        cyc_valid = 1'b1;
        cyc_data  = first_cmd(r_op);
      end
      c_st_addr: begin
        cyc_valid = 1'b1;
        cyc_type  = CYC_ADDR;
        cyc_data  = w_addr_byte;
      end
      c_st_data: begin
        cyc_valid = 1'b1;
        cyc_type  = (r_op == OP_READ) ? CYC_RDATA : CYC_WDATA;
      end
      c_st_cmd2: begin
        cyc_valid = 1'b1;
        cyc_data  = second_cmd(r_op);
      end
      c_st_done: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_op   <= OP_RESET;
      r_addr <= '0;
      r_len  <= '0;
    end else if (w_accept) begin
      r_op   <= op_code_t'(op_code);
      r_addr <= op_addr;
      r_len  <= op_len;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)                   r_addr_cnt <= '0;
    else if (r_state != c_st_addr) r_addr_cnt <= '0;
    else if (w_xfer)              r_addr_cnt <= r_addr_cnt + 3'd1;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)                   r_data_cnt <= '0;
    else if (r_state != c_st_data) r_data_cnt <= '0;
    else if (w_xfer)              r_data_cnt <= r_data_cnt + LEN_W'(1);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)
      r_err_timeout <= 1'b0;
    else if (w_accept)
      r_err_timeout <= 1'b0;
    else if (r_state == c_st_wait_rb && w_timeout && !w_rb_ready)
      r_err_timeout <= 1'b1;
  end

  assign err_timeout = r_err_timeout;

  assign w_start_twb = (r_state != c_st_twb) && (w_state_nxt == c_st_twb);
  assign w_start_trr = (r_state != c_st_trr) && (w_state_nxt == c_st_trr);
  assign w_rb_wait   = (r_state == c_st_wait_rb);

  nand_rb_timer #(
    .TWB_CYC  (TWB_CYC),
    .TRR_CYC  (TRR_CYC),
    .TOUT_W   (TOUT_W),
    .TOUT_CYC (TOUT_CYC)
  ) u_rb_timer (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .F_nRB     (F_nRB),
    .start_twb (w_start_twb),
    .start_trr (w_start_trr),
    .rb_wait   (w_rb_wait),
    .twb_done  (w_twb_done),
    .rb_ready  (w_rb_ready),
    .trr_done  (w_trr_done),
    .timeout   (w_timeout)
  );

endmodule
`default_nettype wire

// File: tb/tb_nand_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_nand_op_sequencer
// Description : Self-checking bench for nand_op_sequencer with a timeline
//               reference model of the NAND operation sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nand_op_sequencer;

  localparam int LEN_W = 12;
  localparam int TWB   = 4;
  localparam int TRR   = 2;
  localparam int TOUT  = 16;

  logic             PCLK = 1'b0;
  logic             PRESET;
  logic             op_valid;
  logic             op_ready;
  logic [1:0]       op_code;
  logic [39:0]      op_addr;
  logic [LEN_W-1:0] op_len;
  logic             cyc_valid;
  logic             cyc_ready;
  logic [1:0]       cyc_type;
  logic [7:0]       cyc_data;
  logic             F_nRB;
  logic             busy;
  logic             done;
  logic             err_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];

  always #5 PCLK = ~PCLK;

  nand_op_sequencer #(
    .LEN_W    (LEN_W),
    .TWB_CYC  (TWB),
    .TRR_CYC  (TRR),
    .TOUT_W   (16),
    .TOUT_CYC (TOUT)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_code     (op_code),
    .op_addr     (op_addr),
    .op_len      (op_len),
    .cyc_valid   (cyc_valid),
    .cyc_ready   (cyc_ready),
    .cyc_type    (cyc_type),
    .cyc_data    (cyc_data),
    .F_nRB       (F_nRB),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout)
  );

  // Expected ordered bus-cycle list for one operation: {type[1:0], data[7:0]}.
  task automatic build_expect(input logic [1:0] op, input logic [39:0] addr,
                              input int len, input bit timed_out);
    exp_q.delete();
    case (op)
      2'd0: exp_q.push_back({2'd0, 8'hFF});
      2'd1: begin
        exp_q.push_back({2'd0, 8'h00});
        for (int i = 0; i < 5; i++) exp_q.push_back({2'd1, addr[8*i +: 8]});
        exp_q.push_back({2'd0, 8'h30});
        if (!timed_out)
          for (int i = 0; i < len; i++) exp_q.push_back({2'd3, 8'h00});
      end
      2'd2: begin
        exp_q.push_back({2'd0, 8'h80});
        for (int i = 0; i < 5; i++) exp_q.push_back({2'd1, addr[8*i +: 8]});
        for (int i = 0; i < len; i++) exp_q.push_back({2'd2, 8'h00});
        exp_q.push_back({2'd0, 8'h10});
      end
      default: begin
        exp_q.push_back({2'd0, 8'h60});
        for (int i = 2; i < 5; i++) exp_q.push_back({2'd1, addr[8*i +: 8]});
        exp_q.push_back({2'd0, 8'hD0});
      end
    endcase
  endtask

  // Runs one operation. busy_len = cycles the device holds F_nRB low after the
  // final command transfers; stall toggles cyc_ready every cycle.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [39:0] addr,
                        input int len, input int busy_len, input bit stall);
    int cyc, c_last, done_cyc, first_rd, last_rd_x, rdy_off, exp_done, nrb_left;
    bit to, prev_pend, busy_ok, stab_ok;
    logic [9:0] prev_cyc;
    // Synced ready is seen 2 clocks after the raw rise, but never before tWB ends.
    rdy_off = TWB + 1;
    if (busy_len > 0 && busy_len + 3 > rdy_off) rdy_off = busy_len + 3;
    to = (rdy_off > TWB + TOUT);
    build_expect(op, addr, len, to);
    got_q.delete();

    @(posedge PCLK); #1;
    op_valid = 1'b1; op_code = op; op_addr = addr; op_len = len[LEN_W-1:0];
    @(negedge PCLK);
    n_tests++;
    if (op_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s op_ready_idle: got %b expected 1", tag, op_ready);
    end
    @(posedge PCLK);

    cyc = 0; c_last = -1; done_cyc = -1; first_rd = -1; last_rd_x = -1;
    nrb_left = 0; prev_pend = 0; busy_ok = 1; stab_ok = 1; prev_cyc = '0;
    while (cyc < 400 && done_cyc < 0) begin
      #1;
      op_valid  = 1'($urandom_range(0, 1));
      op_code   = 2'($urandom);
      op_addr   = {8'($urandom), 32'($urandom)};
      op_len    = LEN_W'($urandom);
      cyc_ready = stall ? (cyc % 2 == 1) : 1'b1;
      if (nrb_left > 0) begin F_nRB = 1'b0; nrb_left--; end
      else F_nRB = 1'b1;
      @(negedge PCLK);
      if (cyc == 0) begin
        n_tests++;
        if (err_timeout !== 1'b0) begin
          n_fail++; $display("FAIL %s err_clear_on_accept: got %b expected 0", tag, err_timeout);
        end
      end
      if (busy !== 1'b1 || op_ready !== 1'b0) busy_ok = 0;
      if (prev_pend && (cyc_valid !== 1'b1 || {cyc_type, cyc_data} !== prev_cyc)) stab_ok = 0;
      if (cyc_valid === 1'b1) begin
        if (cyc_type == 2'd3 && first_rd < 0) first_rd = cyc;
        if (cyc_ready) begin
          got_q.push_back({cyc_type, cyc_data});
          if (cyc_type == 2'd3) last_rd_x = cyc;
          if (cyc_type == 2'd0 && (cyc_data inside {8'hFF, 8'h30, 8'h10, 8'hD0})) begin
            c_last = cyc; nrb_left = busy_len;
          end
          prev_pend = 0;
        end else begin
          prev_pend = 1; prev_cyc = {cyc_type, cyc_data};
        end
      end else prev_pend = 0;
      if (done === 1'b1) done_cyc = cyc;
      @(posedge PCLK);
      cyc++;
    end
    #1;
    op_valid = 1'b0; F_nRB = 1'b1; cyc_ready = 1'b1;

    n_tests++;
    if (done_cyc < 0) begin
      n_fail++; $display("FAIL %s done_seen: got none expected pulse within 400 cycles", tag);
    end
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL %s cycle_count: got %0d expected %0d", tag, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL %s cycle[%0d]: got type %0d data %h expected type %0d data %h",
                           tag, i, got_q[i][9:8], got_q[i][7:0], exp_q[i][9:8], exp_q[i][7:0]);
      end
    end
    n_tests++;
    if (!busy_ok) begin
      n_fail++; $display("FAIL %s busy_during_op: got busy/op_ready wrong expected busy=1 op_ready=0", tag);
    end
    if (stall) begin
      n_tests++;
      if (!stab_ok) begin
        n_fail++; $display("FAIL %s stall_stable: got changed cycle while stalled expected stable", tag);
      end
    end
    if (done_cyc >= 0 && c_last >= 0) begin
      if (to)                           exp_done = c_last + TWB + 1 + TOUT;
      else if (op == 2'd1 && len > 0)   exp_done = last_rd_x + 1;
      else if (op == 2'd1)              exp_done = c_last + rdy_off + TRR;
      else                              exp_done = c_last + rdy_off + 1;
      n_tests++;
      if (done_cyc != exp_done) begin
        n_fail++; $display("FAIL %s done_timing: got cycle %0d expected %0d", tag, done_cyc, exp_done);
      end
      if (op == 2'd1 && len > 0 && !to) begin
        n_tests++;
        if (first_rd != c_last + rdy_off + TRR) begin
          n_fail++; $display("FAIL %s trr_timing: got cycle %0d expected %0d", tag, first_rd, c_last + rdy_off + TRR);
        end
      end
    end

    @(negedge PCLK);
    n_tests++;
    if (op_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cyc_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s idle_after: got ready=%b busy=%b done=%b valid=%b expected 1 0 0 0",
                         tag, op_ready, busy, done, cyc_valid);
    end
    n_tests++;
    if (err_timeout !== to) begin
      n_fail++; $display("FAIL %s err_timeout: got %b expected %b", tag, err_timeout, to);
    end
  endtask

  task automatic test_reset();
    @(negedge PCLK);
    n_tests++;
    if (cyc_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err_timeout !== 1'b0 ||
        cyc_type !== 2'd0 || cyc_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_outputs: got valid=%b busy=%b done=%b err=%b type=%0d data=%h expected all 0",
                         cyc_valid, busy, done, err_timeout, cyc_type, cyc_data);
    end
    @(posedge PCLK); #1 PRESET = 1'b0;
    @(negedge PCLK);
    n_tests++;
    if (op_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_op_ready: got %b expected 1", op_ready);
    end
  endtask

  task automatic test_reset_op();
    run_op("reset_op_twb", 2'd0, 40'h0, 0, 0, 1'b0);
    run_op("reset_op_busy", 2'd0, 40'h0, 0, $urandom_range(6, 14), 1'b0);
  endtask

  task automatic test_read();
    run_op("read_len3", 2'd1, 40'h04_03_02_01_00, 3, 10, 1'b0);
    run_op("read_len0", 2'd1, {8'($urandom), 32'($urandom)}, 0, 7, 1'b0);
  endtask

  task automatic test_program();
    run_op("program_stall", 2'd2, {8'($urandom), 32'($urandom)}, 2, 9, 1'b1);
    run_op("program_len0", 2'd2, {8'($urandom), 32'($urandom)}, 0, 5, 1'b0);
  endtask

  task automatic test_erase();
    run_op("erase", 2'd3, 40'hEE_DD_CC_BB_AA, 0, 12, 1'b0);
  endtask

  task automatic test_timeout();
    run_op("timeout_read", 2'd1, {8'($urandom), 32'($urandom)}, 4, 1000, 1'b0);
    run_op("ready_wins", 2'd3, {8'($urandom), 32'($urandom)}, 0, TWB + TOUT - 3, 1'b0);
    run_op("timeout_edge", 2'd3, {8'($urandom), 32'($urandom)}, 0, TWB + TOUT - 2, 1'b0);
    run_op("after_timeout", 2'd0, 40'h0, 0, 6, 1'b0);
  endtask

  task automatic test_mid_reset();
    int n;
    @(posedge PCLK); #1;
    op_valid = 1'b1; op_code = 2'd1; op_addr = 40'h12_34_56_78_9A; op_len = 12'd4; cyc_ready = 1'b1;
    @(posedge PCLK); #1 op_valid = 1'b0;
    n = 0;
    @(negedge PCLK);
    while (!(cyc_valid === 1'b1 && cyc_type == 2'd1) && n < 20) begin
      @(negedge PCLK); n++;
    end
    n_tests++;
    if (n >= 20) begin
      n_fail++; $display("FAIL mid_reset_addr_seen: got no ADDR cycle expected one within 20 cycles");
    end
    #2 PRESET = 1'b1;
    #1;
    n_tests++;
    if (cyc_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_async: got valid=%b busy=%b expected 0 0", cyc_valid, busy);
    end
    @(posedge PCLK); #1 PRESET = 1'b0;
    @(negedge PCLK);
    n_tests++;
    if (op_ready !== 1'b1 || cyc_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_release: got ready=%b valid=%b expected 1 0", op_ready, cyc_valid);
    end
    run_op("post_reset_op", 2'd0, 40'h0, 0, 8, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++)
      run_op("random", 2'($urandom), {8'($urandom), 32'($urandom)},
             $urandom_range(0, 6), $urandom_range(0, 24), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    PRESET = 1'b0; op_valid = 1'b0; op_code = 2'd0; op_addr = '0; op_len = '0;
    cyc_ready = 1'b1; F_nRB = 1'b1;
    #2 PRESET = 1'b1;
    repeat (2) @(posedge PCLK);
    test_reset();
    test_reset_op();
    test_read();
    test_program();
    test_erase();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
